// File: rtl/seven_segment_mux.sv
// Time-multiplexed seven-segment driver with a double-buffered display register
// that updates only at frame wrap. Define SEVEN_SEGMENT_MUX_LZB_EN for leading-zero blanking.
module seven_segment_mux #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cs,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   bcd_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   output logic [6:0]                seg,
   output logic                      dp,
   output logic [NUM_DIGITS-1:0]     an,
   output logic                      frame_done
);

   localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [PW-1:0]             presc;
   logic [IW-1:0]             idx;
   logic [4*NUM_DIGITS-1:0]   shadow_bcd;
   logic [NUM_DIGITS-1:0]     shadow_dp;
   logic [4*NUM_DIGITS-1:0]   disp_bcd;
   logic [NUM_DIGITS-1:0]     disp_dp;
   logic                      pending;

   logic                      tc;
   logic                      wrap;
   logic [IW-1:0]             idx_nxt;
   logic [4*NUM_DIGITS-1:0]   disp_bcd_nxt;
   logic [NUM_DIGITS-1:0]     disp_dp_nxt;
   logic [3:0]                nib;
   logic                      dp_sel;
   logic [NUM_DIGITS-1:0]     an_nxt;
   logic [6:0]                seg_nxt;
   logic                      blank;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'b1111110;
         4'd1:    decode = 7'b0110000;
         4'd2:    decode = 7'b1101101;
         4'd3:    decode = 7'b1111001;
         4'd4:    decode = 7'b0110011;
         4'd5:    decode = 7'b1011011;
         4'd6:    decode = 7'b1011111;
         4'd7:    decode = 7'b1110000;
         4'd8:    decode = 7'b1111111;
         4'd9:    decode = 7'b1111011;
         default: decode = 7'b0000000;
      endcase
   endfunction

   // Outputs are computed from the post-edge index and display so they carry no extra latency.
   always_comb begin
      tc      = (presc == PW'(REFRESH_DIV - 1));
      wrap    = tc && (idx == IW'(NUM_DIGITS - 1));
      idx_nxt = idx;
      if (tc) begin
         if (idx == IW'(NUM_DIGITS - 1)) idx_nxt = '0;
         else                            idx_nxt = idx + IW'(1);
      end
      disp_bcd_nxt = (wrap && pending) ? shadow_bcd : disp_bcd;
      disp_dp_nxt  = (wrap && pending) ? shadow_dp  : disp_dp;
      nib    = 4'd0;
      dp_sel = 1'b0;
      an_nxt = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         an_nxt[k] = (idx_nxt == IW'(k));
         if (idx_nxt == IW'(k)) begin
            nib    = disp_bcd_nxt[4*k +: 4];
            dp_sel = disp_dp_nxt[k];
         end
      end
   end

`ifdef SEVEN_SEGMENT_MUX_LZB_EN
   logic zero_run;

   // Walk down from the most significant digit; digit 0 is never part of the run.
   always_comb begin
      zero_run = 1'b1;
      blank    = 1'b0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_run = zero_run && (disp_bcd_nxt[4*k +: 4] == 4'd0);
         if ((idx_nxt == IW'(k)) && zero_run) blank = 1'b1;
      end
   end
`else
   assign blank = 1'b0;
`endif

   assign seg_nxt = blank ? 7'b0000000 : decode(nib);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc      <= '0;
         idx        <= '0;
         shadow_bcd <= '0;
         shadow_dp  <= '0;
         disp_bcd   <= '0;
         disp_dp    <= '0;
         pending    <= 1'b0;
         seg        <= '0;
         dp         <= 1'b0;
         an         <= '0;
         frame_done <= 1'b0;
      end else begin
         presc      <= tc ? '0 : presc + PW'(1);
         idx        <= idx_nxt;
         frame_done <= wrap;
         disp_bcd   <= disp_bcd_nxt;
         disp_dp    <= disp_dp_nxt;
         // A load on the wrap edge keeps pending set: the old shadow moves out as the new one lands.
         if (load) begin
            shadow_bcd <= bcd_in;
            shadow_dp  <= dp_in;
            pending    <= 1'b1;
         end else if (wrap) begin
            pending    <= 1'b0;
         end
         seg <= cs ? seg_nxt : 7'b0000000;
         dp  <= cs ? dp_sel  : 1'b0;
         an  <= cs ? an_nxt  : '0;
      end
   end

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed bench for seven_segment_mux with NUM_DIGITS=4, REFRESH_DIV=4 (16-cycle frame).
module tb_seven_segment_mux;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cs = 1'b1;
   logic        load = 1'b0;
   logic [15:0] bcd_in = '0;
   logic [3:0]  dp_in = '0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_done;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef SEVEN_SEGMENT_MUX_LZB_EN
   localparam logic [6:0] LEAD_ZERO = 7'b0000000;
`else
   localparam logic [6:0] LEAD_ZERO = 7'b1111110;
`endif

   seven_segment_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .cs(cs), .load(load), .bcd_in(bcd_in),
      .dp_in(dp_in), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Advances to the negedge on which frame_done is high; ok=0 if none within the budget.
   task automatic wait_fd(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++; if (seg !== 7'b0)   begin n_fail++; $display("FAIL reset_seg got %b want %b", seg, 7'b0); end
      n_checks++; if (an !== 4'b0)    begin n_fail++; $display("FAIL reset_an got %b want %b", an, 4'b0); end
      n_checks++; if (dp !== 1'b0)    begin n_fail++; $display("FAIL reset_dp got %b want 0", dp); end
      n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got %b want 0", frame_done); end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (an !== 4'b0001)     begin n_fail++; $display("FAIL release_an got %b want 0001", an); end
      n_checks++; if (seg !== 7'b1111110) begin n_fail++; $display("FAIL release_seg got %b want 1111110", seg); end
   endtask

   task automatic test_refresh();
      bit ok;
      logic [6:0] exp_seg [4] = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
      logic [3:0] exp_an  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      wait_fd(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL refresh_sync got timeout want frame_done"); end
      load = 1'b1; bcd_in = 16'h1234; dp_in = 4'b0000;
      @(negedge clk);
      load = 1'b0;
      wait_fd(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL refresh_fd got timeout want frame_done"); end
      for (int j = 0; j < 16; j++) begin
         n_checks++; if (an !== exp_an[j/4])   begin n_fail++; $display("FAIL refresh_an[%0d] got %b want %b", j, an, exp_an[j/4]); end
         n_checks++; if (seg !== exp_seg[j/4]) begin n_fail++; $display("FAIL refresh_seg[%0d] got %b want %b", j, seg, exp_seg[j/4]); end
         n_checks++; if (frame_done !== (j == 0)) begin n_fail++; $display("FAIL refresh_fd[%0d] got %b want %b", j, frame_done, j == 0); end
         @(negedge clk);
      end
      n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL refresh_period got %b want 1", frame_done); end
   endtask

   task automatic test_invalid_nibble();
      bit ok;
      load = 1'b1; bcd_in = 16'h00A5; dp_in = 4'b0000;
      @(negedge clk);
      load = 1'b0;
      wait_fd(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL inv_fd got timeout want frame_done"); end
      n_checks++; if (seg !== 7'b1011011) begin n_fail++; $display("FAIL inv_d0_seg got %b want 1011011", seg); end
      repeat (4) @(negedge clk);
      n_checks++; if (an !== 4'b0010)     begin n_fail++; $display("FAIL inv_d1_an got %b want 0010", an); end
      n_checks++; if (seg !== 7'b0000000) begin n_fail++; $display("FAIL inv_d1_seg got %b want 0000000", seg); end
      repeat (4) @(negedge clk);
      n_checks++; if (seg !== LEAD_ZERO)  begin n_fail++; $display("FAIL inv_d2_seg got %b want %b", seg, LEAD_ZERO); end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_cs();
      bit ok;
      repeat (2) @(negedge clk);
      cs = 1'b0;
      for (int t = 3; t <= 16; t++) begin
         @(negedge clk);
         n_checks++; if ({seg, an, dp} !== 12'b0) begin n_fail++; $display("FAIL cs_blank[%0d] got seg=%b an=%b dp=%b want 0", t, seg, an, dp); end
         n_checks++; if (frame_done !== (t == 16)) begin n_fail++; $display("FAIL cs_fd[%0d] got %b want %b", t, frame_done, t == 16); end
      end
      repeat (2) @(negedge clk);
      cs = 1'b1;
      @(negedge clk);
      n_checks++; if (an !== 4'b0001)     begin n_fail++; $display("FAIL cs_resume_an got %b want 0001", an); end
      n_checks++; if (seg !== 7'b1011011) begin n_fail++; $display("FAIL cs_resume_seg got %b want 1011011", seg); end
      wait_fd(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL cs_resync got timeout want frame_done"); end
   endtask

   task automatic test_back_to_back();
      logic [6:0] exp;
      for (int t = 1; t <= 48; t++) begin
         @(negedge clk);
         if (t % 16 == 0) begin
            n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL b2b_fd[%0d] got %b want 1", t, frame_done); end
         end
         if (t >= 16 && t % 4 == 0) begin
            exp = (t < 32) ? 7'b0110000 : 7'b1101101;
            n_checks++; if (seg !== exp) begin n_fail++; $display("FAIL b2b_seg[%0d] got %b want %b", t, seg, exp); end
         end
         load = 1'b0;
         if (t == 2)  begin load = 1'b1; bcd_in = 16'h1111; end
         if (t == 15) begin load = 1'b1; bcd_in = 16'h2222; end
      end
   endtask

   task automatic test_lzb();
      bit ok;
      load = 1'b1; bcd_in = 16'h0070; dp_in = 4'b1000;
      @(negedge clk);
      load = 1'b0;
      wait_fd(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL lzb_fd got timeout want frame_done"); end
      n_checks++; if ({seg, dp} !== {7'b1111110, 1'b0}) begin n_fail++; $display("FAIL lzb_d0 got seg=%b dp=%b want 1111110/0", seg, dp); end
      repeat (4) @(negedge clk);
      n_checks++; if (seg !== 7'b1110000) begin n_fail++; $display("FAIL lzb_d1 got %b want 1110000", seg); end
      repeat (4) @(negedge clk);
      n_checks++; if (seg !== LEAD_ZERO) begin n_fail++; $display("FAIL lzb_d2 got %b want %b", seg, LEAD_ZERO); end
      repeat (4) @(negedge clk);
      n_checks++; if ({an, seg, dp} !== {4'b1000, LEAD_ZERO, 1'b1}) begin n_fail++; $display("FAIL lzb_d3 got an=%b seg=%b dp=%b want 1000/%b/1", an, seg, dp, LEAD_ZERO); end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit ok;
      load = 1'b1; bcd_in = 16'h1234; dp_in = 4'b1111;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if ({seg, an, dp, frame_done} !== 13'b0) begin n_fail++; $display("FAIL rstmid_async got seg=%b an=%b dp=%b fd=%b want 0", seg, an, dp, frame_done); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if ({an, seg, dp} !== {4'b0001, 7'b1111110, 1'b0}) begin n_fail++; $display("FAIL rstmid_release got an=%b seg=%b dp=%b want 0001/1111110/0", an, seg, dp); end
      wait_fd(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_fd got timeout want frame_done"); end
      n_checks++; if ({seg, dp} !== {7'b1111110, 1'b0}) begin n_fail++; $display("FAIL rstmid_lost got seg=%b dp=%b want 1111110/0", seg, dp); end
   endtask

   initial begin
      #2 rst_n = 1'b0;
      test_reset();
      test_refresh();
      test_invalid_nibble();
      test_cs();
      test_back_to_back();
      test_lzb();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
